// File: rtl/fetch_stage.sv
// Instruction fetch: issues in-order imem requests, buffers returned words, tracks sequential PCs.
// Redirect flushes the buffer and discards in-flight responses. Stall holds the buffer head.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic          grant, push, pop, fifo_nempty;
    logic [31:0]   occupancy;

    assign fifo_nempty = (count_q != '0);
    assign pop         = fifo_nempty && !stall && !redirect;
    assign push        = imem_rvalid && (drop_q == '0) && !redirect;
    assign grant       = imem_req && imem_gnt;

    // Buffered plus live in-flight words; a pop this cycle frees a slot before any new response lands.
    always_comb begin
        occupancy = 32'(count_q) + 32'(outst_q) - 32'(drop_q);
        imem_req  = rst && !redirect
                 && (32'(outst_q) < 32'(MAX_OUTSTANDING))
                 && (occupancy < 32'(FIFO_DEPTH) + 32'(pop));
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            head_pc_d  = redirect_pc;
            outst_d    = outst_q - OW'(imem_rvalid);
            drop_d     = outst_q - OW'(imem_rvalid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + OW'(grant) - OW'(imem_rvalid);
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                head_pc_d = head_pc_q + 32'd4;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = fifo_nempty;
    assign instruction = fifo_nempty ? mem_q[rd_ptr_q] : NOP;
    assign pc          = head_pc_q;
    assign pc_plus4    = head_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector table for fetch_stage driven against a queue-based 1-cycle memory model.
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        gnt;
        logic        rsp;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pcv;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 30;
    localparam logic [31:0] NOP = 32'h13;
    vec_t        vecs [NV];
    logic [31:0] q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t v(input logic stl, input logic rdr, input logic [31:0] rpc,
                               input logic gnt, input logic rsp, input logic vld,
                               input logic [31:0] ins, input logic [31:0] pcv,
                               input logic req, input logic [31:0] addr);
        vec_t r;
        r.stl = stl; r.rdr = rdr; r.rpc = rpc; r.gnt = gnt; r.rsp = rsp;
        r.vld = vld; r.ins = ins; r.pcv = pcv; r.req = req; r.addr = addr;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic        granted, rv;
        logic [31:0] gaddr;
        //        stl rdr rpc        gnt rsp vld ins           pc         req addr
        vecs[0]  = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h0,     1, 32'h0);
        vecs[1]  = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h0,     1, 32'h4);
        vecs[2]  = v(0, 0, 32'h0,    1, 1, 1, 32'hA000,     32'h0,     1, 32'h8);
        vecs[3]  = v(0, 0, 32'h0,    1, 1, 1, 32'hA004,     32'h4,     1, 32'hC);
        vecs[4]  = v(0, 0, 32'h0,    1, 1, 1, 32'hA008,     32'h8,     1, 32'h10);
        vecs[5]  = v(0, 0, 32'h0,    1, 1, 1, 32'hA00C,     32'hC,     1, 32'h14);
        vecs[6]  = v(1, 0, 32'h0,    1, 1, 1, 32'hA010,     32'h10,    0, 32'h18);
        vecs[7]  = v(1, 0, 32'h0,    1, 1, 1, 32'hA010,     32'h10,    0, 32'h18);
        vecs[8]  = v(1, 0, 32'h0,    1, 1, 1, 32'hA010,     32'h10,    0, 32'h18);
        vecs[9]  = v(1, 0, 32'h0,    1, 1, 1, 32'hA010,     32'h10,    0, 32'h18);
        vecs[10] = v(0, 0, 32'h0,    1, 1, 1, 32'hA010,     32'h10,    1, 32'h18);
        vecs[11] = v(0, 0, 32'h0,    1, 1, 1, 32'hA014,     32'h14,    1, 32'h1C);
        vecs[12] = v(0, 0, 32'h0,    1, 1, 1, 32'hA018,     32'h18,    1, 32'h20);
        vecs[13] = v(0, 0, 32'h0,    1, 0, 1, 32'hA01C,     32'h1C,    1, 32'h24);
        vecs[14] = v(0, 1, 32'h100,  1, 0, 0, NOP,          32'h20,    0, 32'h28);
        vecs[15] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h100,   0, 32'h100);
        vecs[16] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h100,   1, 32'h100);
        vecs[17] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h100,   1, 32'h104);
        vecs[18] = v(0, 0, 32'h0,    1, 1, 1, 32'hA100,     32'h100,   1, 32'h108);
        vecs[19] = v(1, 1, 32'h200,  1, 1, 1, 32'hA104,     32'h104,   0, 32'h10C);
        vecs[20] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h200,   1, 32'h200);
        vecs[21] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h200,   1, 32'h204);
        vecs[22] = v(0, 0, 32'h0,    0, 1, 1, 32'hA200,     32'h200,   1, 32'h208);
        vecs[23] = v(0, 0, 32'h0,    0, 1, 1, 32'hA204,     32'h204,   1, 32'h208);
        vecs[24] = v(0, 0, 32'h0,    0, 1, 0, NOP,          32'h208,   1, 32'h208);
        vecs[25] = v(0, 0, 32'h0,    0, 1, 0, NOP,          32'h208,   1, 32'h208);
        vecs[26] = v(0, 0, 32'h0,    0, 1, 0, NOP,          32'h208,   1, 32'h208);
        vecs[27] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h208,   1, 32'h208);
        vecs[28] = v(0, 0, 32'h0,    1, 1, 0, NOP,          32'h208,   1, 32'h20C);
        vecs[29] = v(0, 0, 32'h0,    1, 1, 1, 32'hA208,     32'h208,   1, 32'h210);

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", -1, 32'(instr_valid), 32'd0);
        chk("rst_instr", -1, instruction, NOP);
        chk("rst_req",   -1, 32'(imem_req), 32'd0);
        chk("rst_pc",    -1, pc, 32'h0);
        chk("rst_pc4",   -1, pc_plus4, 32'h4);
        chk("rst_addr",  -1, imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall       = vecs[i].stl;
            redirect    = vecs[i].rdr;
            redirect_pc = vecs[i].rpc;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rsp && (q.size() > 0);
            imem_rdata  = (q.size() > 0) ? q[0] + 32'hA000 : 32'hDEAD_BEEF;
            #1;
            chk("valid", i, 32'(instr_valid), 32'(vecs[i].vld));
            chk("instr", i, instruction, vecs[i].ins);
            chk("pc",    i, pc, vecs[i].pcv);
            chk("pc4",   i, pc_plus4, vecs[i].pcv + 32'd4);
            chk("req",   i, 32'(imem_req), 32'(vecs[i].req));
            chk("addr",  i, imem_addr, vecs[i].addr);
            granted = imem_req && imem_gnt;
            gaddr   = imem_addr;
            rv      = imem_rvalid;
            @(posedge clk);
            if (rv) void'(q.pop_front());
            if (granted) q.push_back(gaddr);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle with a response pending.
        stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        chk("mrst_valid", NV, 32'(instr_valid), 32'd0);
        chk("mrst_instr", NV, instruction, NOP);
        chk("mrst_req",   NV, 32'(imem_req), 32'd0);
        chk("mrst_pc",    NV, pc, 32'h0);
        chk("mrst_addr",  NV, imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_req",  NV + 1, 32'(imem_req), 32'd1);
        chk("post_addr", NV + 1, imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
